// File: rtl/vga_timing_gen.sv
// VGA timing and pixel generator: divides the system clock down to a pixel tick,
// counts h/v positions, and registers sync, active flag and pattern colour per pixel.
module vga_timing_gen #(
  parameter int               RGB_W    = 12,
  parameter int               CLK_DIV  = 4,
  parameter int               H_ACTIVE = 640,
  parameter int               H_FP     = 16,
  parameter int               H_SYNC   = 96,
  parameter int               H_BP     = 48,
  parameter int               V_ACTIVE = 480,
  parameter int               V_FP     = 10,
  parameter int               V_SYNC   = 2,
  parameter int               V_BP     = 33,
  parameter bit               HS_POL   = 1'b0,
  parameter bit               VS_POL   = 1'b0,
  parameter logic [RGB_W-1:0] SOLID    = RGB_W'(12'hF00),
  parameter int               CHK_LOG2 = 5,
  parameter int               XW       = 10,
  parameter int               YW       = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] pixel_in,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic             pix_tick,
  output logic             frame_start,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CH_W    = RGB_W / 3;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XW-1:0]    H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]    V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0]    H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [YW-1:0]    V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [XW-1:0]    HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]    HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0]    VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0]    VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0]    BAR_WX   = XW'(BAR_W);

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps each channel
  // to the inverse of one bit of the bar index.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [XW-1:0] hpos);
    logic [XW-1:0] idx;
    logic [2:0]    bar;
    idx = hpos / BAR_WX;
    bar = (idx > XW'(7)) ? 3'd7 : idx[2:0];
    return {{CH_W{~bar[1]}}, {CH_W{~bar[2]}}, {CH_W{~bar[0]}}};
  endfunction

  function automatic logic [RGB_W-1:0] pattern(input logic [1:0]       md,
                                                input logic [XW-1:0]    hpos,
                                                input logic [YW-1:0]    vpos,
                                                input logic [RGB_W-1:0] pix);
    logic [RGB_W-1:0] c;
    case (md)
      2'd0:    c = pix;
      2'd1:    c = SOLID;
      2'd2:    c = bar_colour(hpos);
      default: c = {RGB_W{hpos[CHK_LOG2] ^ vpos[CHK_LOG2]}};
    endcase
    return c;
  endfunction

  logic             run_q;
  logic [DIV_W-1:0] div_p0;
  logic [XW-1:0]    h_p0;
  logic [YW-1:0]    v_p0;
  logic [1:0]       mode_q;
  logic             vld_p0;
  logic             fs_p0;
  logic [1:0]       mode_eff;

  logic             video_on_p1;
  logic             hsync_p1;
  logic             vsync_p1;
  logic [RGB_W-1:0] rgb_p1;

  // run_q keeps pix_tick low during reset even when CLK_DIV=1.
  assign vld_p0   = run_q & en & (div_p0 == DIV_LAST);
  assign fs_p0    = vld_p0 & (h_p0 == '0) & (v_p0 == '0);
  // The mode latched at frame_start already governs pixel (0,0) of that frame.
  assign mode_eff = fs_p0 ? mode : mode_q;

  // ---- stage p0: divider and h/v position counters ----
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      run_q  <= 1'b0;
      div_p0 <= '0;
      h_p0   <= '0;
      v_p0   <= '0;
      mode_q <= 2'd0;
    end else begin
      run_q <= 1'b1;
      if (!en) begin
        div_p0 <= '0;
        h_p0   <= '0;
        v_p0   <= '0;
      end else begin
        div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
        if (vld_p0) begin
          if (h_p0 == H_LAST) begin
            h_p0 <= '0;
            v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
          end else begin
            h_p0 <= h_p0 + 1'b1;
          end
        end
      end
      if (fs_p0) mode_q <= mode;
    end
  end

  // ---- stage p1: registered sync, active flag and colour for the ticked pixel ----
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      video_on_p1 <= 1'b0;
      hsync_p1    <= ~HS_POL;
      vsync_p1    <= ~VS_POL;
      rgb_p1      <= '0;
    end else if (!en) begin
      video_on_p1 <= 1'b0;
      hsync_p1    <= ~HS_POL;
      vsync_p1    <= ~VS_POL;
      rgb_p1      <= '0;
    end else if (vld_p0) begin
      video_on_p1 <= (h_p0 < H_ACT_X) && (v_p0 < V_ACT_Y);
      hsync_p1    <= ((h_p0 >= HS_START) && (h_p0 < HS_END)) ? HS_POL : ~HS_POL;
      vsync_p1    <= ((v_p0 >= VS_START) && (v_p0 < VS_END)) ? VS_POL : ~VS_POL;
      rgb_p1      <= ((h_p0 < H_ACT_X) && (v_p0 < V_ACT_Y))
                     ? pattern(mode_eff, h_p0, v_p0, pixel_in) : '0;
    end
  end

  assign x           = h_p0;
  assign y           = v_p0;
  assign pix_tick    = vld_p0;
  assign frame_start = fs_p0;
  assign video_on    = video_on_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign rgb         = rgb_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-size timing config checked cycle by cycle
// against a behavioural model, with scenario tasks for periods, patterns and control.
module tb_vga_timing_gen;

  localparam int       RGB_W    = 12;
  localparam int       CLK_DIV  = 2;
  localparam int       H_ACTIVE = 64;
  localparam int       H_FP     = 4;
  localparam int       H_SYNC   = 8;
  localparam int       H_BP     = 4;
  localparam int       V_ACTIVE = 6;
  localparam int       V_FP     = 1;
  localparam int       V_SYNC   = 2;
  localparam int       V_BP     = 1;
  localparam bit       HS_POL   = 1'b0;
  localparam bit       VS_POL   = 1'b1;
  localparam int       CHK_LOG2 = 2;
  localparam int       XW       = 10;
  localparam int       YW       = 10;
  localparam int       H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int       V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int       FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;

  typedef struct packed {
    logic        vo;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  logic             clk = 1'b0;
  logic             clk_run = 1'b1;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [RGB_W-1:0] pixel_in = '0;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             pix_tick, frame_start, video_on, hsync, vsync;
  logic [RGB_W-1:0] rgb;

  int vectors = 0;
  int miscompares = 0;

  int   m_div, m_h, m_v;
  logic [1:0] m_mode;
  out_t m_held;
  out_t sb_q[$];
  bit   pt = 0;
  logic obs_tick, obs_fs;
  logic [XW-1:0] obs_x;
  logic [YW-1:0] obs_y;
  int   last_h, last_v;

  logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  vga_timing_gen #(
    .RGB_W(RGB_W), .CLK_DIV(CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .SOLID(12'hF00),
    .CHK_LOG2(CHK_LOG2), .XW(XW), .YW(YW)
  ) dut (
    .clk_100MHz(clk), .reset(reset), .en(en), .mode(mode), .pixel_in(pixel_in),
    .x(x), .y(y), .pix_tick(pix_tick), .frame_start(frame_start),
    .video_on(video_on), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic out_t idle_out();
    out_t o;
    o.vo = 1'b0; o.hs = ~HS_POL; o.vs = ~VS_POL; o.rgb = 12'h000;
    return o;
  endfunction

  function automatic out_t model_out(int h, int v, logic [1:0] md, logic [11:0] pix);
    out_t o;
    o.vo = (h < H_ACTIVE) && (v < V_ACTIVE);
    o.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
    o.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
    if (!o.vo) o.rgb = 12'h000;
    else begin
      case (md)
        2'd0:    o.rgb = pix;
        2'd1:    o.rgb = 12'hF00;
        2'd2:    o.rgb = bar_tab[h / (H_ACTIVE / 8)];
        default: o.rgb = ((((h >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) == 1) ? 12'hFFF : 12'h000;
      endcase
    end
    return o;
  endfunction

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0; m_mode = 2'd0;
    m_held = idle_out();
    sb_q.delete();
  endtask

  // One clock: check combinational timing against the model, queue the expected
  // registered outputs, clock, then pop and compare.
  task automatic cycle();
    logic tick, fs, en_pre;
    logic [11:0] exp_pix;
    out_t e, got;
    if (pt) pixel_in = {x[3:0], y[3:0], 4'h5};
    else    pixel_in = 12'($urandom);
    exp_pix = pt ? {m_h[3:0], m_v[3:0], 4'h5} : pixel_in;
    en_pre = en;
    tick = en && (m_div == CLK_DIV - 1);
    fs   = tick && (m_h == 0) && (m_v == 0);
    obs_tick = pix_tick; obs_fs = frame_start; obs_x = x; obs_y = y;
    vectors++;
    if (pix_tick !== tick || frame_start !== fs || x !== XW'(m_h) || y !== YW'(m_v)) begin
      miscompares++;
      $display("FAIL timing: pix_tick=%b frame_start=%b x=%0d y=%0d, want %b %b %0d %0d",
               pix_tick, frame_start, x, y, tick, fs, m_h, m_v);
    end
    if (!en) e = idle_out();
    else if (tick) e = model_out(m_h, m_v, fs ? mode : m_mode, exp_pix);
    else e = m_held;
    sb_q.push_back(e);
    if (fs) m_mode = mode;
    last_h = m_h; last_v = m_v;
    @(posedge clk); #1;
    if (!en_pre) begin
      m_div = 0; m_h = 0; m_v = 0;
    end else begin
      m_div = (m_div == CLK_DIV - 1) ? 0 : m_div + 1;
      if (tick) begin
        if (m_h == H_TOTAL - 1) begin
          m_h = 0;
          m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
        end else m_h = m_h + 1;
      end
    end
    m_held = sb_q.pop_front();
    got = {video_on, hsync, vsync, rgb};
    vectors++;
    if (got !== m_held) begin
      miscompares++;
      $display("FAIL outputs after h=%0d v=%0d: vo=%b hs=%b vs=%b rgb=%h, want vo=%b hs=%b vs=%b rgb=%h",
               last_h, last_v, got.vo, got.hs, got.vs, got.rgb,
               m_held.vo, m_held.hs, m_held.vs, m_held.rgb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; mode = 2'd2; pt = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (x !== '0 || y !== '0 || pix_tick !== 1'b0 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_timing: x=%0d y=%0d tick=%b fs=%b, want 0 0 0 0", x, y, pix_tick, frame_start);
    end
    vectors++;
    if (video_on !== 1'b0 || rgb !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_video: video_on=%b rgb=%h, want 0 000", video_on, rgb);
    end
    vectors++;
    if (hsync !== 1'b1 || vsync !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sync: hsync=%b vsync=%b, want 1 0", hsync, vsync);
    end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_tick_period();
    int prev = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_tick) begin
        vectors++;
        if (prev < 0) begin
          if (obs_fs !== 1'b1) begin
            miscompares++;
            $display("FAIL first_tick_fs: frame_start=%b, want 1", obs_fs);
          end
        end else if (i - prev != CLK_DIV) begin
          miscompares++;
          $display("FAIL tick_period: %0d clk, want %0d", i - prev, CLK_DIV);
        end
        prev = i;
      end
    end
  endtask

  task automatic test_bars();
    logic [11:0] exp_bar [9] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F,
                                 12'hF00, 12'h00F, 12'h000, 12'h000};
    int seen = 0;
    for (int i = 0; i < 2 * H_TOTAL * CLK_DIV; i++) begin
      cycle();
      if (obs_tick && last_v == 1 && last_h % 8 == 0 && last_h <= 64) begin
        vectors++;
        seen++;
        if (rgb !== exp_bar[last_h / 8]) begin
          miscompares++;
          $display("FAIL bar x=%0d: rgb=%h, want %h", last_h, rgb, exp_bar[last_h / 8]);
        end
      end
    end
    vectors++;
    if (seen != 9) begin
      miscompares++;
      $display("FAIL bar_samples: %0d, want 9", seen);
    end
  endtask

  task automatic test_hsync();
    int act = 0;
    int start_h = -1;
    logic prev = hsync;
    for (int i = 0; i < H_TOTAL * CLK_DIV; i++) begin
      cycle();
      if (obs_tick) begin
        if (hsync === HS_POL) act++;
        if (hsync === HS_POL && prev !== HS_POL) start_h = last_h;
        prev = hsync;
      end
    end
    vectors++;
    if (act != H_SYNC) begin
      miscompares++;
      $display("FAIL hsync_width: %0d ticks, want %0d", act, H_SYNC);
    end
    vectors++;
    if (start_h != H_ACTIVE + H_FP) begin
      miscompares++;
      $display("FAIL hsync_start: registered at h=%0d, want %0d", start_h, H_ACTIVE + H_FP);
    end
  endtask

  task automatic test_frame();
    int n = 0;
    int vo = 0;
    int vs = 0;
    do begin cycle(); n++; end while (!obs_fs && n < 2 * FRAME_CLK);
    vectors++;
    if (!obs_fs) begin
      miscompares++;
      $display("FAIL frame_wait: no frame_start in %0d clk, want one", n);
    end
    n = 0;
    do begin
      cycle(); n++;
      if (obs_tick) begin
        if (video_on === 1'b1) vo++;
        if (vsync === VS_POL) vs++;
      end
    end while (!obs_fs && n < 2 * FRAME_CLK);
    vectors++;
    if (n != FRAME_CLK) begin
      miscompares++;
      $display("FAIL frame_period: %0d clk, want %0d", n, FRAME_CLK);
    end
    vectors++;
    if (vo != H_ACTIVE * V_ACTIVE) begin
      miscompares++;
      $display("FAIL video_on_count: %0d, want %0d", vo, H_ACTIVE * V_ACTIVE);
    end
    vectors++;
    if (vs != V_SYNC * H_TOTAL) begin
      miscompares++;
      $display("FAIL vsync_width: %0d ticks, want %0d", vs, V_SYNC * H_TOTAL);
    end
  endtask

  task automatic test_mode_switch();
    int n = 0;
    int white = 0;
    int other = 0;
    mode = 2'd3;
    do begin cycle(); n++; end while (!obs_fs && n < 2 * FRAME_CLK);
    n = 0;
    do begin cycle(); n++; end while (!(obs_tick && last_v == 3) && n < 2 * FRAME_CLK);
    vectors++;
    if (!(obs_tick && last_v == 3)) begin
      miscompares++;
      $display("FAIL switch_wait: line 3 not reached, last v=%0d", last_v);
    end
    mode = 2'd1;
    n = 0;
    do begin
      cycle(); n++;
      if (obs_tick && !obs_fs && video_on === 1'b1) begin
        if (rgb === 12'hFFF) white++;
        else if (rgb !== 12'h000) other++;
      end
    end while (!obs_fs && n < 2 * FRAME_CLK);
    vectors++;
    if (other != 0 || white == 0) begin
      miscompares++;
      $display("FAIL checker_tail: white=%0d other=%0d, want white>0 other=0", white, other);
    end
    vectors++;
    if (rgb !== 12'hF00) begin
      miscompares++;
      $display("FAIL solid_first_pixel: rgb=%h, want f00", rgb);
    end
  endtask

  task automatic test_passthrough();
    int n = 0;
    int hits = 0;
    mode = 2'd0;
    pt = 1;
    do begin cycle(); n++; end while (!obs_fs && n < 2 * FRAME_CLK);
    vectors++;
    if (rgb !== 12'h005) begin
      miscompares++;
      $display("FAIL pass_origin: rgb=%h, want 005", rgb);
    end
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (obs_tick && last_h == 17 && last_v == 0) begin
        hits++;
        vectors++;
        if (rgb !== 12'h105) begin
          miscompares++;
          $display("FAIL pass_x17: rgb=%h, want 105", rgb);
        end
      end
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("FAIL pass_samples: %0d, want 1", hits);
    end
  endtask

  task automatic test_en_toggle();
    int n = 0;
    repeat (40) cycle();
    en = 1'b0;
    repeat (4) cycle();
    vectors++;
    if (video_on !== 1'b0 || rgb !== 12'h000 || hsync !== ~HS_POL || vsync !== ~VS_POL ||
        x !== '0 || y !== '0 || pix_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low: vo=%b rgb=%h hs=%b vs=%b x=%0d y=%0d tick=%b, want 0 000 %b %b 0 0 0",
               video_on, rgb, hsync, vsync, x, y, pix_tick, ~HS_POL, ~VS_POL);
    end
    en = 1'b1;
    do begin cycle(); n++; end while (!obs_tick && n < 10);
    vectors++;
    if (obs_tick !== 1'b1 || obs_fs !== 1'b1 || obs_x !== '0 || obs_y !== '0) begin
      miscompares++;
      $display("FAIL reenable_first_tick: tick=%b fs=%b x=%0d y=%0d, want 1 1 0 0",
               obs_tick, obs_fs, obs_x, obs_y);
    end
  endtask

  task automatic test_async_reset();
    repeat (30) cycle();
    vectors++;
    if (video_on !== 1'b1 || rgb === 12'h000) begin
      miscompares++;
      $display("FAIL pre_reset_active: vo=%b rgb=%h, want 1 and nonzero", video_on, rgb);
    end
    @(negedge clk);
    clk_run = 1'b0;
    #2 reset = 1'b0;
    #2;
    vectors++;
    if (hsync !== ~HS_POL || vsync !== ~VS_POL || rgb !== 12'h000 || video_on !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_out: hs=%b vs=%b rgb=%h vo=%b, want %b %b 000 0",
               hsync, vsync, rgb, video_on, ~HS_POL, ~VS_POL);
    end
    vectors++;
    if (x !== '0 || y !== '0 || pix_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_cnt: x=%0d y=%0d tick=%b, want 0 0 0", x, y, pix_tick);
    end
    #2 reset = 1'b1;
    model_reset();
    clk_run = 1'b1;
    repeat (2 * H_TOTAL * CLK_DIV) cycle();
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_bars();
    test_hsync();
    test_frame();
    test_mode_switch();
    test_passthrough();
    test_en_toggle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and pixel generator; successor to the fixed 640x480 top-level VGA block.
- Sits between the 100 MHz system clock and the VGA DAC pins.
- Derives the pixel tick with an integer divider and generates hsync/vsync with configurable porches and polarity.
- Exports pixel coordinates so upstream logic can supply pixels; otherwise drives one of four built-in patterns.

Parameters:
- RGB_W, 12, rgb width; must be a multiple of 3 (R/G/B each RGB_W/3, R in MSBs)
- CLK_DIV, 4, clk_100MHz cycles per pixel (>=1)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines
- HS_POL, 0, hsync level during the sync pulse
- VS_POL, 0, vsync level during the sync pulse
- SOLID, 12'hF00, colour for mode 1
- CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels
- XW, 10; YW, 10: coordinate widths

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  timing enable
- mode  in  2  0=pass-through, 1=solid, 2=colour bars, 3=checkerboard
- pixel_in  in  RGB_W  pixel for the current (x,y), used in mode 0
- x  out  XW  current horizontal counter
- y  out  YW  current vertical counter
- pix_tick  out  1  one-cycle strobe per pixel
- frame_start  out  1  one-cycle strobe at (0,0)
- video_on  out  1  registered active-area flag
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb  out  RGB_W  registered pixel colour

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Reset (reset=0, asynchronous):
  - div, h, v counters = 0; x = 0, y = 0.
  - pix_tick = 0, frame_start = 0, video_on = 0, rgb = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL; mode_q = 0.
- Divider:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_tick = 1 for one clk when div == CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is constantly 1 while en=1.
- Counters advance only on pix_tick:
  - h increments and wraps H_TOTAL-1 -> 0.
  - On the h wrap, v increments and wraps V_TOTAL-1 -> 0.
  - x = h and y = v, driven directly from the counter registers.
- frame_start = pix_tick & (h==0) & (v==0). The first strobe after reset or re-enable comes on the first tick.
- Output stage, registered on pix_tick; reflects the (h,v) present at that tick, so outputs lag x/y by one pixel period. Upstream has one full pixel period to present pixel_in for (x,y).
  - video_on = (h < H_ACTIVE) & (v < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - rgb = 0 when not active; otherwise the pattern selected by mode_q.
- Patterns:
  - Mode 0: pixel_in.
  - Mode 1: SOLID.
  - Mode 2: bar = h / (H_ACTIVE/8), 0..7, clamped to 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - Mode 3: h[CHK_LOG2] ^ v[CHK_LOG2]; 1 = white (all ones), 0 = black.
- Mode latch: mode_q <= mode only on the frame_start cycle. A mid-frame mode change takes effect at the next frame; no tearing.
- en=0:
  - Synchronously clears div/h/v.
  - pix_tick = 0, frame_start = 0, video_on = 0, rgb = 0; syncs inactive.
  - mode_q holds.
  - On re-assertion, timing restarts at (0,0) with a fresh frame_start.
- Reset mid-frame: all state returns to reset values immediately; no partial-frame recovery.

Test Plan:
- Default params, release reset, en=1:
  - pix_tick period = 4 clk.
  - hsync low for 96 ticks, going low one tick after h=656; line period 3200 clk.
  - vsync low for 2 lines; frame period 1,680,000 clk.
- Small config (H 8/2/3/3, V 4/1/2/1, CLK_DIV=2, HS_POL=VS_POL=1):
  - hsync high for h=10..12 (delayed one tick), vsync high for v=5..6.
  - video_on high for exactly 32 ticks per frame; frame_start every 256 clk.
- Mode 2, default timing:
  - rgb = FFF for x=0..79, then FF0 at x=80, 0FF at x=160 ... 000 at x=560..639.
  - rgb = 0 at x>=640.
- Mode switch 3 -> 1 mid-frame at v=100:
  - Checkerboard continues to the end of the frame.
  - The first active pixel after the next frame_start shows SOLID=F00.
- Mode 0, pixel_in = {x[3:0], y[3:0], 4'h5}: rgb at each tick equals the value derived from the previous tick's x/y.
- Async reset pulse mid-line with clk stopped: hsync/vsync return to ~POL and rgb to 0 without a clock edge. en dropped then raised: frame_start on the first tick, x=y=0.
